// File: rtl/ball_render_if.sv
// Pixel-stream bundle between the sync generator / controller and ball_render.
// master drives coordinates, syncs and run; slave (ball_render) returns colour,
// delayed syncs and the bounce count.
interface ball_render_if;
   logic [10:0] x;
   logic [10:0] y;
   logic        video_on;
   logic        hsync;
   logic        vsync;
   logic        run;
   logic [11:0] rgb;
   logic        hsync_o;
   logic        vsync_o;
   logic [7:0]  bounce_cnt;

   modport master (
      output x, y, video_on, hsync, vsync, run,
      input  rgb, hsync_o, vsync_o, bounce_cnt
   );

   modport slave (
      input  x, y, video_on, hsync, vsync, run,
      output rgb, hsync_o, vsync_o, bounce_cnt
   );
endinterface

// File: rtl/ball_render.sv
// Bouncing-ball pixel generator: registered RGB plus 1-cycle delayed syncs.
// Optional screen border (white outline) enabled by defining BALL_BORDER_EN.
module ball_render #(
   parameter int unsigned H_RES      = 1024,
   parameter int unsigned V_RES      = 768,
   parameter int unsigned BALL_SIZE  = 16,
   parameter int unsigned SPEED      = 2,
   parameter logic [11:0] BALL_COLOR = 12'hF00,
   parameter logic [11:0] BG_COLOR   = 12'h000
) (
   input logic          clk,
   input logic          rstn,
   ball_render_if.slave bus
);

   localparam logic [11:0] LimX   = 12'(H_RES - BALL_SIZE);
   localparam logic [11:0] LimY   = 12'(V_RES - BALL_SIZE);
   localparam logic [11:0] Spd    = 12'(SPEED);
   localparam logic [11:0] Size   = 12'(BALL_SIZE);
   localparam logic [10:0] StartX = 11'((H_RES - BALL_SIZE) / 2);
   localparam logic [10:0] StartY = 11'((V_RES - BALL_SIZE) / 2);

   // One axis step; returns {contact, new_dir, new_pos}. All maths at 12 bits.
   function automatic logic [12:0] step_axis(input logic [10:0] pos, input logic dir,
                                             input logic [11:0] lim);
      logic [11:0] p;
      p = {1'b0, pos};
      if (dir) begin
         if (p + Spd >= lim) return {1'b1, 1'b0, lim[10:0]};
         else                return {1'b0, 1'b1, 11'(p + Spd)};
      end else begin
         if (p <= Spd)       return {1'b1, 1'b1, 11'd0};
         else                return {1'b0, 1'b0, 11'(p - Spd)};
      end
   endfunction

   logic [10:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
   logic [7:0]  bounce_q, bounce_d;
   logic [11:0] rgb_q, rgb_d;
   logic        hsync_q, vsync_q;
   // Set once vsync has been seen high after reset, so vsync held low across
   // reset release cannot masquerade as a falling edge.
   logic        armed_q;
   logic        tick;
   logic        hit;
   logic [12:0] nx, ny;
   logic [11:0] xe, ye, bxe, bye;

   assign tick = vsync_q & ~bus.vsync & armed_q;

   // Ball motion and bounce counting, applied only on a running frame tick.
   always_comb begin
      ball_x_d = ball_x_q;
      ball_y_d = ball_y_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      bounce_d = bounce_q;
      nx       = step_axis(ball_x_q, dir_x_q, LimX);
      ny       = step_axis(ball_y_q, dir_y_q, LimY);
      if (tick && bus.run) begin
         ball_x_d = nx[10:0];
         dir_x_d  = nx[11];
         ball_y_d = ny[10:0];
         dir_y_d  = ny[11];
         if (nx[12] || ny[12]) bounce_d = bounce_q + 8'd1;
      end
   end

   // Hit test and colour selection for the current pixel.
   always_comb begin
      xe    = {1'b0, bus.x};
      ye    = {1'b0, bus.y};
      bxe   = {1'b0, ball_x_q};
      bye   = {1'b0, ball_y_q};
      hit   = bus.video_on && (xe >= bxe) && (xe < bxe + Size) &&
              (ye >= bye) && (ye < bye + Size);
      rgb_d = 12'h000;
      if (bus.video_on) begin
         if (hit) begin
            rgb_d = BALL_COLOR;
`ifdef BALL_BORDER_EN
         end else if (bus.x == 11'd0 || bus.x == 11'(H_RES - 1) ||
                      bus.y == 11'd0 || bus.y == 11'(V_RES - 1)) begin
            rgb_d = 12'hFFF;
`endif
         end else begin
            rgb_d = BG_COLOR;
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ball_x_q <= StartX;
         ball_y_q <= StartY;
         dir_x_q  <= 1'b1;
         dir_y_q  <= 1'b1;
         bounce_q <= 8'd0;
         rgb_q    <= 12'h000;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         armed_q  <= 1'b0;
      end else begin
         ball_x_q <= ball_x_d;
         ball_y_q <= ball_y_d;
         dir_x_q  <= dir_x_d;
         dir_y_q  <= dir_y_d;
         bounce_q <= bounce_d;
         rgb_q    <= rgb_d;
         hsync_q  <= bus.hsync;
         vsync_q  <= bus.vsync;
         armed_q  <= armed_q | bus.vsync;
      end
   end

   assign bus.rgb        = rgb_q;
   assign bus.hsync_o    = hsync_q;
   assign bus.vsync_o    = vsync_q;
   assign bus.bounce_cnt = bounce_q;

endmodule

// File: doc/ball_render.md
# ball_render

Pixel-generation stage that sits directly downstream of the 1024x768 sync generator. It consumes the pixel coordinate, `video_on`, `hsync` and `vsync` from that generator and produces registered 12-bit RGB. It renders a square ball over a flat background. The ball position advances once per frame during vertical blanking and bounces off the screen edges. The block also delays `hsync`/`vsync` so that sync and colour leave the block aligned.

## Interface
Parameters:
- `H_RES`, 1024, active pixels per line.
- `V_RES`, 768, active lines per frame.
- `BALL_SIZE`, 16, ball edge length in pixels.
- `SPEED`, 2, pixels moved per frame on each axis. Valid range is 1..15.
- `BALL_COLOR`, 12'hF00, ball RGB (4:4:4).
- `BG_COLOR`, 12'h000, background RGB.

Ports:
- `clk`  in  1  pixel clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `x`  in  11  pixel x from the sync generator. It is 0 outside the active area.
- `y`  in  11  pixel y from the sync generator. It is 0 outside the active area.
- `video_on`  in  1  high when (x, y) is inside the active area.
- `hsync`  in  1  horizontal sync, active-low.
- `vsync`  in  1  vertical sync, active-low.
- `run`  in  1  when high, the ball moves at each frame tick.
- `rgb`  out  12  registered pixel colour {R[3:0], G[3:0], B[3:0]}.
- `hsync_o`  out  1  `hsync` delayed one cycle.
- `vsync_o`  out  1  `vsync` delayed one cycle.
- `bounce_cnt`  out  8  number of frames in which a wall contact occurred. Wraps 255 -> 0.

## Operation
- Frame tick:
  - `vsync_d` is the registered copy of `vsync`.
  - `tick = vsync_d & ~vsync` (falling edge of `vsync`). It fires exactly once per frame, at the start of vertical sync.
- State registers:
  - `ball_x`, `ball_y`: 11 bits each, top-left corner of the ball.
  - `dir_x`, `dir_y`: 1 bit each. 1 means +x / +y.
- Position update happens on the edge where `tick=1 && run=1`. Otherwise position and direction hold.
- Per-axis update, shown for x. Y is identical using `V_RES` and `dir_y`. Let `LIM = H_RES - BALL_SIZE`.
  - `dir_x=1`, `ball_x + SPEED >= LIM`: `ball_x <= LIM`, `dir_x <= 0`, contact.
  - `dir_x=1`, otherwise: `ball_x <= ball_x + SPEED`.
  - `dir_x=0`, `ball_x <= SPEED`: `ball_x <= 0`, `dir_x <= 1`, contact.
  - `dir_x=0`, otherwise: `ball_x <= ball_x - SPEED`.
- Width rule: all comparisons are done at 12 bits, so the sum cannot overflow. There is no signed arithmetic.
- `bounce_cnt` increments by 1 on any update with contact on either axis. A simultaneous x and y contact (corner) counts as 1.
- Hit test: `hit = video_on && ball_x <= x < ball_x+BALL_SIZE && ball_y <= y < ball_y+BALL_SIZE`.
- Colour selection, in priority order:
  - `video_on=0` → 12'h000.
  - `hit` → `BALL_COLOR`.
  - Otherwise → `BG_COLOR` (see Configuration for the border option).
- Position changes only during vblank, so a frame never shows a torn ball.

## Timing
- Latency is 1 cycle from `x`/`y`/`video_on`/`hsync`/`vsync` to `rgb`/`hsync_o`/`vsync_o`. All outputs are registered.
- Reset values:
  - `rgb` = 0, `hsync_o` = 1, `vsync_o` = 1, `bounce_cnt` = 0.
  - `vsync_d` = 1.
  - `ball_x` = (H_RES-BALL_SIZE)/2 = 504, `ball_y` = (V_RES-BALL_SIZE)/2 = 376.
  - `dir_x` = 1, `dir_y` = 1.
- Reset asserted mid-frame: all state returns to reset values on that edge. After release, no tick fires until the next genuine 1→0 transition of `vsync`. `vsync` held low across reset release does not produce a tick.
- `vsync` held low for 6 lines produces one tick only.
- When `run` is deasserted, tick detection continues; only motion is suppressed.

## Configuration
- `BALL_BORDER_EN` defined:
  - When `video_on=1` and x==0, x==H_RES-1, y==0 or y==V_RES-1, `rgb` is 12'hFFF.
  - Priority: ball > border > background.
- Not defined: there is no border logic and those pixels render `BG_COLOR`.

## Test plan
- Reset: hold `rstn=0` for 2 clocks → `rgb`=000, `hsync_o`=`vsync_o`=1, ball at (504,376), `bounce_cnt`=0.
- Pipeline: `video_on=1` with (504,376) → `rgb`=F00 next cycle. (520,376) → 000. `video_on=0` at (504,376) → 000. An `hsync` low pulse appears on `hsync_o` exactly 1 cycle later.
- Tick: `run=1`, one `vsync` 1→0 edge, then `vsync` held low 6 lines → ball at (506,378), moved once only.
- Bounce: `run=1`, default params, 188 ticks → `ball_y`=752, `dir_y`=0, `bounce_cnt`=1, `ball_x`=880. Tick 252 → `ball_x`=1008, `dir_x`=0, `ball_y`=624, `bounce_cnt`=2.
- Hold and reset: with `run=0`, 10 ticks → position unchanged. Assert `rstn=0` mid-frame with `vsync` low, then release → ball at (504,376), and no tick until the next `vsync` falling edge.
- Macro: `video_on=1` at (0,100) → `rgb`=FFF with `BALL_BORDER_EN`, and 000 without it.
